load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Memory stage directly downstream of the ALU. Takes ALUResult as the byte address and rs2 data as WriteData.
//   Performs RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) on a local byte-enabled synchronous data RAM.
//   Loads take two cycles; the unit stalls the core for the first cycle. Stores complete in one cycle.
// PARAMETERS
//   ADDR_W   8     word-address width; RAM depth = 2**ADDR_W 32-bit words
// PORTS
//   clk          in   1   single clock; all state updates on rising edge
//   reset        in   1   synchronous, active-high reset
//   MemRead      in   1   load request, held by core until unstalled
//   MemWrite     in   1   store request
//   funct3       in   3   access size/sign, RV32I encoding
//   ALUResult    in   32  byte address from ALU
//   WriteData    in   32  store data, LSB-aligned
//   ReadData     out  32  extended load result
//   Stall        out  1   freeze PC/pipeline this cycle
//   Fault        out  1   one-cycle pulse: misaligned / illegal request dropped
// BEHAVIOUR
//   Reset (sync): state=IDLE, ReadData=0, Fault=0, captured addr/funct3=0; RAM contents NOT cleared.
//   Word index = ALUResult[ADDR_W+1:2]; upper address bits ignored, so addresses wrap modulo RAM size.
//   Legality, evaluated in IDLE only:
//     - funct3 011/110/111 is illegal.
//     - MemRead&MemWrite together is illegal.
//     - Stores with funct3 100/101 are illegal.
//     - Halfword with addr[0]=1 is misaligned; word with addr[1:0]!=0 is misaligned.
//     - Illegal or misaligned: no RAM access, no stall, registered Fault=1 next cycle for one cycle.
//   FSM IDLE:
//     - Legal MemRead: Stall=1 (combinational, same cycle); RAM read issued; addr[1:0] and funct3 captured.
//       Next state LOAD_WAIT.
//     - Legal MemWrite: byte enables from size and addr[1:0]; data replicated into lanes.
//       Written at the edge; Stall=0; stay IDLE.
//     - No request: Stall=0, nothing changes.
//   FSM LOAD_WAIT:
//     - Stall=0. Select the lane from the RAM output using the captured addr[1:0].
//     - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//     - ReadData is valid combinationally this cycle and registered at the edge, holding until the next load completes.
//     - Core inputs are ignored; the still-asserted MemRead does not re-issue. Next state IDLE unconditionally.
//   Back-to-back loads: a new load in the cycle after LOAD_WAIT returns to IDLE stalls again. Throughput is one load per 2 cycles.
//   Stall is 0 whenever reset=1. Reset during LOAD_WAIT gives IDLE next cycle; the load is abandoned and ReadData=0.
//   Read-after-write to the same word on consecutive cycles returns the new data (write commits before the read edge).
// STRUCTURE
//   lsu_pkg:
//     - F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
//     - state enum {IDLE, LOAD_WAIT}
//     - byte-enable and lane-extract functions
//   Sub-module dmem_sram (ADDR_W): 32-bit synchronous RAM, 4 byte write-enables, 1-cycle read latency, no reset.
//   Top level holds the FSM, legality check, write-lane steering and load extension.
// TESTING
//   1 SW 0xDEADBEEF @0x10, then LW @0x10 -> Stall=1 for 1 cycle; next cycle ReadData=0xDEADBEEF.
//   2 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
//   3 SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001; bytes 0x20-0x21 unchanged.
//   4 LW @0x11, SH @0x23, funct3=011 -> no write, Stall=0, Fault pulses 1 cycle each; RAM unchanged.
//   5 Assert reset in LOAD_WAIT -> IDLE, ReadData=0, Stall=0. Then LW @0x10 -> data still 0x80ADBEEF.
//   6 ADDR_W=8: SW 0x12345678 @0x400, then LW @0x000 -> 0x12345678 (wrap). Back-to-back LWs -> Stall pattern 1,0,1,0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types, funct3 encodings and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, LOAD_WAIT} lsu_state_t;

  // Byte enables for a store of the given size at byte offset off.
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate LSB-aligned store data into every lane it could land in.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {4{wd[7:0]}};
      2'b01:   lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  // Pull the addressed lane out of a RAM word and sign/zero extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [31:0] shifted;
    logic [31:0] value;
    shifted = word >> {off, 3'b000};
    case (f3)
      F3_B:    value = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   value = {24'h000000, shifted[7:0]};
      F3_H:    value = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   value = {16'h0000, shifted[15:0]};
      default: value = word;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-to-LSU memory-stage bus: request fields from the core, result/stall/fault back.
interface load_store_unit_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Fault;

  modport master (
    output MemRead, MemWrite, funct3, ALUResult, WriteData,
    input  ReadData, Stall, Fault
  );

  modport slave (
    input  MemRead, MemWrite, funct3, ALUResult, WriteData,
    output ReadData, Stall, Fault
  );
endinterface

// File: rtl/load_store_unit_dmem_sram.sv
// Byte-enabled 32-bit synchronous data RAM, one-cycle read latency, contents not reset.
module dmem_sram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Write enabled byte lanes and register the read word on the same edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: legality check, store lane steering, two-cycle loads with one stall cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  lsu_state_t        state_q, state_d;
  logic              req, req_ok, f3_ok, aligned;
  logic              issue_load, issue_store, fault_d;
  logic [1:0]        off, cap_off;
  logic [2:0]        cap_f3;
  logic [31:0]       read_q, load_value, ram_rdata, ram_wdata;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] word_addr;

  assign req       = bus.MemRead | bus.MemWrite;
  assign off       = bus.ALUResult[1:0];
  assign word_addr = bus.ALUResult[ADDR_W+1:2];

  // Decide whether the current request is well formed and naturally aligned.
  always_comb begin
    f3_ok   = 1'b1;
    aligned = 1'b1;
    case (bus.funct3)
      3'b011, 3'b110, 3'b111: f3_ok = 1'b0;
      default:                f3_ok = 1'b1;
    endcase
    case (bus.funct3[1:0])
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    req_ok = f3_ok && aligned && !(bus.MemRead && bus.MemWrite) &&
             !(bus.MemWrite && bus.funct3[2]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a legal load moves to LOAD_WAIT, which always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (issue_load) state_d = LOAD_WAIT;
      LOAD_WAIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs: requests are only accepted in IDLE and never while reset is high.
  always_comb begin
    issue_load  = 1'b0;
    issue_store = 1'b0;
    fault_d     = 1'b0;
    if (!reset && state_q == IDLE && req) begin
      if (req_ok) begin
        issue_load  = bus.MemRead;
        issue_store = bus.MemWrite;
      end else begin
        fault_d = 1'b1;
      end
    end
  end

  assign bus.Stall = issue_load;
  assign ram_we    = issue_store ? byte_enable(bus.funct3, off) : 4'b0000;
  assign ram_wdata = store_lanes(bus.funct3, bus.WriteData);

  dmem_sram #(.ADDR_W(ADDR_W)) u_dmem (
    .clk   (clk),
    .we    (ram_we),
    .re    (issue_load),
    .addr  (word_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Remember lane offset and size of the load in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_off <= 2'b00;
      cap_f3  <= 3'b000;
    end else if (issue_load) begin
      cap_off <= off;
      cap_f3  <= bus.funct3;
    end
  end

  assign load_value = load_extract(ram_rdata, cap_off, cap_f3);

  // Keep the last completed load result and the registered fault pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_q  <= 32'h0;
      bus.Fault <= 1'b0;
    end else begin
      if (state_q == LOAD_WAIT) read_q <= load_value;
      bus.Fault <= fault_d;
    end
  end

  assign bus.ReadData = (state_q == LOAD_WAIT) ? load_value : read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, directed cases, then random traffic.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 8;
  localparam int NBYTES = 4 * (2**ADDR_W);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  memModel [NBYTES];
  logic [31:0] loadQ [$];
  bit          faultQ [$];
  logic [31:0] lastRd = 32'h0;
  bit          prevStall = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic bit modelLegal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd && wr) return 1'b0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if (wr && (f3 == F3_BU || f3 == F3_HU)) return 1'b0;
    if ((f3 == F3_H || f3 == F3_HU) && a[0]) return 1'b0;
    if (f3 == F3_W && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int accessBytes(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU) return 1;
    if (f3 == F3_H || f3 == F3_HU) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int base = int'(a[ADDR_W+1:0]);
    int n = accessBytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = memModel[(base + i) % NBYTES];
    if (f3 == F3_B && v[7])  v = v | 32'hFFFFFF00;
    if (f3 == F3_H && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic modelStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int base = int'(a[ADDR_W+1:0]);
    int n = accessBytes(f3);
    for (int i = 0; i < n; i++) memModel[(base + i) % NBYTES] = d[8*i +: 8];
  endtask

  // Issue one core request starting just after a rising edge; covers the LOAD_WAIT cycle of legal loads.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d);
    bit req = rd || wr;
    bit ok  = req && modelLegal(rd, wr, f3, a);
    bit expStall = ok && rd;
    bus.MemRead = rd; bus.MemWrite = wr; bus.funct3 = f3; bus.ALUResult = a; bus.WriteData = d;
    if (req && !ok) faultQ.push_back(1'b1);
    if (ok && wr) modelStore(f3, a, d);
    if (ok && rd) loadQ.push_back(modelLoad(f3, a));
    @(negedge clk);
    checkOutput("stall_issue", {31'b0, bus.Stall}, {31'b0, expStall});
    @(posedge clk); #1;
    if (expStall) begin
      bus.MemWrite  = 1'($urandom_range(0, 1));
      bus.funct3    = 3'($urandom);
      bus.ALUResult = $urandom;
      bus.WriteData = $urandom;
      @(negedge clk);
      checkOutput("stall_wait", {31'b0, bus.Stall}, 32'h0);
      @(posedge clk); #1;
    end
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
  endtask

  task automatic expectHeld(input string name, input logic [31:0] value);
    @(negedge clk);
    checkOutput(name, bus.ReadData, value);
    @(posedge clk); #1;
  endtask

  // Monitor: pops expected load data in the cycle after a stall and matches fault pulses.
  always @(negedge clk) begin
    if (reset) begin
      lastRd    = 32'h0;
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        if (loadQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL load_unexpected: got 0x%08h with no load pending", bus.ReadData);
        end else begin
          lastRd = loadQ.pop_front();
          checkOutput("load_data", bus.ReadData, lastRd);
        end
      end else begin
        checkOutput("read_hold", bus.ReadData, lastRd);
      end
      if (bus.Fault) begin
        checks++;
        if (faultQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL fault_unexpected: got Fault=1 expected Fault=0");
        end else begin
          void'(faultQ.pop_front());
        end
      end
      prevStall = bus.Stall;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  f3;
    int          kind;
    bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.funct3 = F3_W;
    bus.ALUResult = 32'h10; bus.WriteData = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset_stall", {31'b0, bus.Stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; bus.MemRead = 1'b0;
    @(negedge clk);
    checkOutput("reset_readdata", bus.ReadData, 32'h0);
    checkOutput("reset_fault", {31'b0, bus.Fault}, 32'h0);
    @(posedge clk); #1;

    $display("[TB] filling RAM");
    for (int w = 0; w < 2**ADDR_W; w++) applyStimulus(1'b0, 1'b1, F3_W, 32'(w * 4), $urandom);

    $display("[TB] directed cases");
    applyStimulus(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    expectHeld("t1_lw", 32'hDEADBEEF);

    applyStimulus(1'b0, 1'b1, F3_B, 32'h13, 32'h00000080);
    applyStimulus(1'b1, 1'b0, F3_B, 32'h13, 32'h0);
    expectHeld("t2_lb", 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, F3_BU, 32'h13, 32'h0);
    expectHeld("t2_lbu", 32'h00000080);
    applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    expectHeld("t2_lw", 32'h80ADBEEF);

    applyStimulus(1'b0, 1'b1, F3_H, 32'h22, 32'h00008001);
    applyStimulus(1'b1, 1'b0, F3_H, 32'h22, 32'h0);
    expectHeld("t3_lh", 32'hFFFF8001);
    applyStimulus(1'b1, 1'b0, F3_HU, 32'h22, 32'h0);
    expectHeld("t3_lhu", 32'h00008001);
    applyStimulus(1'b1, 1'b0, F3_HU, 32'h20, 32'h0);

    applyStimulus(1'b1, 1'b0, F3_W, 32'h11, 32'h0);
    applyStimulus(1'b0, 1'b1, F3_H, 32'h23, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    applyStimulus(1'b0, 1'b1, F3_BU, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b1, F3_W, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b0, F3_W, 32'h20, 32'h0);
    applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    expectHeld("t4_ram_unchanged", 32'h80ADBEEF);

    bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.funct3 = F3_W; bus.ALUResult = 32'h10;
    @(negedge clk);
    checkOutput("t5_issue_stall", {31'b0, bus.Stall}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_reset_stall", {31'b0, bus.Stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; bus.MemRead = 1'b0;
    @(negedge clk);
    checkOutput("t5_readdata_cleared", bus.ReadData, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
    expectHeld("t5_after_reset", 32'h80ADBEEF);

    applyStimulus(1'b0, 1'b1, F3_W, 32'h400, 32'h12345678);
    applyStimulus(1'b1, 1'b0, F3_W, 32'h000, 32'h0);
    expectHeld("t6_wrap", 32'h12345678);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, F3_W, 32'(i * 4), 32'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      f3   = 3'($urandom);
      a    = $urandom;
      d    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      if (kind < 4)       applyStimulus(1'b1, 1'b0, f3, a, d);
      else if (kind < 8)  applyStimulus(1'b0, 1'b1, f3, a, d);
      else if (kind == 8) applyStimulus(1'b0, 1'b0, f3, a, d);
      else                applyStimulus(1'b1, 1'b1, f3, a, d);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("loads_drained", 32'(loadQ.size()), 32'h0);
    checkOutput("faults_drained", 32'(faultQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
